// File: rtl/left_shift_seq.sv
// Iterative left shifter/rotator: one power-of-two stage per clock, MSB stage first,
// with valid/ready handshakes on the operand and result sides.
module left_shift_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               rot,
  input  logic               fill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int unsigned CntW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SHAMT_W - 1);
  localparam logic [SHAMT_W:0] WidthL = (SHAMT_W + 1)'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               rot_q, rot_d;
  logic               fill_q, fill_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [SHAMT_W:0]   stage_amt;
  logic [SHAMT_W:0]   wrap_amt;
  logic [WIDTH-1:0]   low_bits;
  logic [WIDTH-1:0]   stage_data;

  // Stage k moves by 2**k; low_bits supplies the vacated LSBs (wrapped MSBs or fill).
  always_comb begin
    stage_amt = (SHAMT_W + 1)'(1) << cnt_q;
    wrap_amt  = WidthL - stage_amt;
    if (rot_q) begin
      low_bits = data_q >> wrap_amt;
    end else if (fill_q) begin
      low_bits = ~({WIDTH{1'b1}} << stage_amt);
    end else begin
      low_bits = '0;
    end
    stage_data = shamt_q[cnt_q] ? ((data_q << stage_amt) | low_bits) : data_q;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    res_d   = res_q;
    shamt_d = shamt_q;
    rot_d   = rot_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          shamt_d = shamt;
          rot_d   = rot;
          fill_d  = fill;
          cnt_d   = CntMax;
          state_d = StShift;
        end
      end
      StShift: begin
        data_d = stage_data;
        if (cnt_q == '0) begin
          res_d   = stage_data;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      res_q   <= '0;
      shamt_q <= '0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
      cnt_q   <= CntMax;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      res_q   <= res_d;
      shamt_q <= shamt_d;
      rot_q   <= rot_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result lives in its own register so out_data holds between operations.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = res_q;

endmodule
